// File: rtl/multiplier_lut_pkg.sv
// ---------------------------------------------------------------------------
// multiplier_lut_pkg
// Shared constants and elaboration-time helpers for the LUT multiplier.
//   WIDTH_MAX  : largest supported operand width (LUT of 2^(2*WIDTH_MAX) rows)
//   prod_w()   : product width for a given operand width
//   build_lut(): constant function producing the ROM image, row {a,b} = a*b
// ---------------------------------------------------------------------------
package multiplier_lut_pkg;

    localparam int WIDTH_MAX     = 4;
    localparam int PROD_W_MAX    = 2 * WIDTH_MAX;
    localparam int LUT_DEPTH_MAX = 1 << PROD_W_MAX;

    // The image is always sized for WIDTH_MAX; smaller widths use the low
    // rows and the low product bits only.
    typedef logic [LUT_DEPTH_MAX-1:0][PROD_W_MAX-1:0] lut_img_t;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // Row index is {a,b}: a lives in the upper 'width' bits of the index.
    function automatic lut_img_t build_lut(input int width);
        lut_img_t img;
        int       mask;
        img  = '0;
        mask = (1 << width) - 1;
        for (int idx = 0; idx < (1 << (2 * width)); idx++) begin
            img[idx] = PROD_W_MAX'(((idx >> width) & mask) * (idx & mask));
        end
        return img;
    endfunction

endpackage

// File: rtl/multiplier_lut_rom.sv
// ---------------------------------------------------------------------------
// multiplier_lut_rom
// Combinational product ROM. The table is a constant built at elaboration;
// there is no write port.
//   a, b : unsigned operands (WIDTH bits each)
//   z    : a*b (2*WIDTH bits), exact, no truncation
// ---------------------------------------------------------------------------
module multiplier_lut_rom
    import multiplier_lut_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] z
);

    localparam int       PW  = prod_w(WIDTH);
    localparam lut_img_t LUT = build_lut(WIDTH);

    // Zero-extend the {a,b} index to the full table address width.
    logic [PROD_W_MAX-1:0] idx;

    assign idx = PROD_W_MAX'({a, b});
    assign z   = LUT[idx][PW-1:0];

endmodule

// File: rtl/multiplier_lut.sv
// ---------------------------------------------------------------------------
// multiplier_lut
// Unsigned WIDTH x WIDTH multiplier implemented as a constant lookup table,
// with a combinational product, a registered valid-qualified copy, and an
// optional sticky self-check against arithmetic a*b.
//
// Optional feature macro: MULTIPLIER_LUT_CHECK_EN (adds lut_err + checker).
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   a, b      : unsigned operands (WIDTH bits)
//   in_valid  : qualifies a/b for the registered path
//   z         : combinational product a*b
//   z_q       : registered product, updated when in_valid=1
//   out_valid : z_q holds a product captured on the previous edge
//   lut_err   : sticky ROM-vs-arithmetic mismatch (check build only)
// ---------------------------------------------------------------------------
module multiplier_lut
    import multiplier_lut_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic [2*WIDTH-1:0] z,
    output logic [2*WIDTH-1:0] z_q,
    output logic               out_valid
`ifdef MULTIPLIER_LUT_CHECK_EN
    ,
    output logic               lut_err
`endif
);

    localparam int PW = prod_w(WIDTH);

    generate
        if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("multiplier_lut: WIDTH must be in 1..%0d", WIDTH_MAX);
        end
    endgenerate

    logic [PW-1:0] rom_z;

    multiplier_lut_rom #(
        .WIDTH (WIDTH)
    ) u_rom (
        .a (a),
        .b (b),
        .z (rom_z)
    );

    assign z = rom_z;

    // Registered path
    logic [PW-1:0] z_q_d, z_q_q;
    logic          valid_d, valid_q;

    always_comb begin
        z_q_d   = z_q_q;
        valid_d = in_valid;
        if (in_valid) begin
            z_q_d = rom_z;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            z_q_q   <= z_q_d;
            valid_q <= valid_d;
        end
    end

    assign z_q       = z_q_q;
    assign out_valid = valid_q;

`ifdef MULTIPLIER_LUT_CHECK_EN
    // Independent arithmetic reference; any disagreement with the ROM on a
    // valid edge latches the error until reset.
    logic [PW-1:0] ref_prod;
    logic          lut_err_d, lut_err_q;

    always_comb begin
        ref_prod  = PW'(a) * PW'(b);
        lut_err_d = lut_err_q;
        if (in_valid && (rom_z != ref_prod)) begin
            lut_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lut_err_q <= 1'b0;
        end else begin
            lut_err_q <= lut_err_d;
        end
    end

    assign lut_err = lut_err_q;
`endif

endmodule

// File: tb/tb_multiplier_lut.sv
// ---------------------------------------------------------------------------
// tb_multiplier_lut
// Scoreboard bench: the stimulus side pushes the expected registered product
// for every accepted vector; a negedge monitor pops and compares whenever
// out_valid is high, and otherwise checks that z_q holds (or is 0 after a
// reset edge). The combinational z is checked right after each input change.
// ---------------------------------------------------------------------------
module tb_multiplier_lut;

`ifdef MULTIPLIER_LUT_CHECK_EN
    localparam int W = 4;
`else
    localparam int W = 2;
`endif
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a, b;
    logic          in_valid;
    logic [PW-1:0] z, z_q;
    logic          out_valid;
`ifdef MULTIPLIER_LUT_CHECK_EN
    logic          lut_err;
`endif

    multiplier_lut #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .z         (z),
        .z_q       (z_q),
        .out_valid (out_valid)
`ifdef MULTIPLIER_LUT_CHECK_EN
        ,
        .lut_err   (lut_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [PW-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. A vector is expected on z_q only if it is
    // presented with in_valid=1 outside reset.
    task automatic step(input int av, input int bv, input int v, input int r,
                        input int exp_z, input int check_z);
        @(posedge clk);
        #1;
        a        = W'(av);
        b        = W'(bv);
        in_valid = v[0];
        rst_n    = r[0];
        if (v != 0 && r != 0) sb.push_back(PW'(exp_z));
        #1;
        if (check_z != 0) chk("z_comb", 32'(z), 32'(exp_z));
    endtask

    // Monitor: prev_rst is the reset level seen by the upcoming edge.
    logic          prev_rst = 1'b0;
    logic [PW-1:0] hold     = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!prev_rst) begin
                chk("rst_z_q", 32'(z_q), 32'd0);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                hold = '0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    logic [PW-1:0] e;
                    e = sb.pop_front();
                    chk("z_q", 32'(z_q), 32'(e));
                    hold = e;
                end
            end else begin
                chk("hold_z_q", 32'(z_q), 32'(hold));
            end
            prev_rst = rst_n;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct { int a; int b; int p; } vec_t;
    vec_t dir_vecs[8] = '{
        '{0, 0, 0}, '{0, 2, 0}, '{2, 1, 2}, '{2, 2, 4},
        '{3, 0, 0}, '{3, 3, 9}, '{1, 3, 3}, '{2, 3, 6}
    };

    initial begin
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;

        // Reset, with in_valid low
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
`ifdef MULTIPLIER_LUT_CHECK_EN
        @(negedge clk);
        chk("rst_lut_err", 32'(lut_err), 32'd0);
`endif

        // Directed vectors, back-to-back valid (no bubbles)
        foreach (dir_vecs[i]) step(dir_vecs[i].a, dir_vecs[i].b, 1, 1, dir_vecs[i].p, 1);

        // Registered path: capture 3*2, then hold with in_valid=0
        step(3, 2, 1, 1, 6, 1);
        step(1, 1, 0, 1, 1, 1);
        step(2, 1, 0, 1, 2, 1);

        // Reset mid-stream drops the product presented in the reset cycle
        step(3, 3, 1, 0, 9, 1);
        step(3, 3, 1, 1, 9, 1);
        step(1, 2, 1, 1, 2, 1);
        step(0, 0, 0, 1, 0, 1);

        // Random traffic against the a*b model
        for (int i = 0; i < 200; i++) begin
            int ra, rb, rv;
            ra = int'($urandom_range((1 << W) - 1, 0));
            rb = int'($urandom_range((1 << W) - 1, 0));
            rv = int'($urandom_range(1, 0));
            step(ra, rb, rv, 1, ra * rb, 1);
        end

`ifdef MULTIPLIER_LUT_CHECK_EN
        // Exhaustive sweep including 15*15=225; checker must stay quiet
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                step(ia, ib, 1, 1, ia * ib, 1);
        step(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk("lut_err_clean", 32'(lut_err), 32'd0);

        // Corrupt the ROM output for one valid vector
        force dut.rom_z = '0;
        step(15, 15, 1, 1, 0, 0);
        step(1, 1, 0, 1, 1, 0);
        release dut.rom_z;
        @(negedge clk);
        chk("lut_err_set", 32'(lut_err), 32'd1);
        step(2, 3, 1, 1, 6, 1);
        step(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk("lut_err_sticky", 32'(lut_err), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk("lut_err_cleared", 32'(lut_err), 32'd0);
`endif

        // Drain the scoreboard
        for (int i = 0; i < 10 && sb.size() != 0; i++) step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
